// File: rtl/uriscv_axi_sram.sv
`default_nettype none
// ============================================================================
// Module   : uriscv_axi_sram
// Brief    : AXI responder (4-bit len, no IDs) fronting a 1W/1R word SRAM;
//            concurrent write (AW/W/B) and read (AR/R) FSMs.
// Option   : AXI_SRAM_DECERR_EN - out-of-range beats answer DECERR (2'b11)
//            instead of aliasing modulo MEM_WORDS.
// Revision : 1.0 - initial release
// ============================================================================
module uriscv_axi_sram #(
  parameter int unsigned MEM_WORDS = 16384,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter string       INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic [3:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic        rlast,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready
);
  localparam int unsigned IDX_W     = $clog2(MEM_WORDS);
  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) * 33'd4;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_e;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_FETCH = 2'd1, R_DATA = 2'd2} rstate_e;

  logic [31:0] mem [MEM_WORDS];

  // WRAP with an illegal length degrades to INCR; oversize beats step one word.
  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [3:0] len,
                                            input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] incr;
    logic [31:0] mask;
    incr = 32'd1 << ((size > 3'd2) ? 3'd2 : size);
    mask = (({28'd0, len} + 32'd1) * incr) - 32'd1;
    next_addr = addr + incr;
    if (burst == 2'b00)
      next_addr = addr;
    else if (burst == 2'b10 && (len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15))
      next_addr = (addr & ~mask) | ((addr + incr) & mask);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
    word_idx = IDX_W'((addr - BASE_ADDR) >> 2);
  endfunction

  function automatic logic out_of_range(input logic [31:0] addr);
    out_of_range = ({1'b0, addr - BASE_ADDR} >= MEM_BYTES);
  endfunction

  // ---------------- write channel ----------------
  wstate_e     wstate_q;
  logic [31:0] waddr_q, waddr_d;
  logic [3:0]  wlen_q, wcnt_q;
  logic [2:0]  wsize_q;
  logic [1:0]  wburst_q, bresp_q;
  logic        werr_q, wbeat_err, we;
  logic        unused_wlast;

  assign unused_wlast = wlast;
  assign waddr_d      = next_addr(waddr_q, wlen_q, wsize_q, wburst_q);
`ifdef AXI_SRAM_DECERR_EN
  assign wbeat_err = out_of_range(waddr_q);
`else
  assign wbeat_err = 1'b0;
`endif
  assign we      = (wstate_q == W_DATA) && wvalid && !rst && !wbeat_err;
  assign awready = (wstate_q == W_IDLE) && !rst;
  assign wready  = (wstate_q == W_DATA);
  assign bvalid  = (wstate_q == W_RESP);
  assign bresp   = bresp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wstate_q <= W_IDLE;
      waddr_q  <= '0;
      wlen_q   <= '0;
      wcnt_q   <= '0;
      wsize_q  <= '0;
      wburst_q <= '0;
      bresp_q  <= '0;
      werr_q   <= 1'b0;
    end else begin
      case (wstate_q)
        W_IDLE: if (awvalid) begin
          waddr_q  <= awaddr;
          wlen_q   <= awlen;
          wsize_q  <= awsize;
          wburst_q <= awburst;
          wcnt_q   <= '0;
          werr_q   <= 1'b0;
          wstate_q <= W_DATA;
        end
        W_DATA: if (wvalid) begin
          waddr_q <= waddr_d;
          wcnt_q  <= wcnt_q + 4'd1;
          werr_q  <= werr_q | wbeat_err;
          if (wcnt_q == wlen_q) begin
            bresp_q  <= (werr_q || wbeat_err) ? 2'b11 : 2'b00;
            wstate_q <= W_RESP;
          end
        end
        W_RESP: if (bready) begin
          bresp_q  <= 2'b00;
          wstate_q <= W_IDLE;
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[word_idx(waddr_q)][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  rstate_e     rstate_q;
  logic [31:0] raddr_q, raddr_d, rdata_q;
  logic [3:0]  rlen_q, rcnt_q;
  logic [2:0]  rsize_q;
  logic [1:0]  rburst_q, rresp_q;
  logic        rvalid_q, rlast_q, rbeat_err;

  assign raddr_d = next_addr(raddr_q, rlen_q, rsize_q, rburst_q);
`ifdef AXI_SRAM_DECERR_EN
  assign rbeat_err = out_of_range(raddr_q);
`else
  assign rbeat_err = 1'b0;
`endif
  assign arready = (rstate_q == R_IDLE) && !rst;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rlast   = rlast_q;
  assign rresp   = rresp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rstate_q <= R_IDLE;
      raddr_q  <= '0;
      rlen_q   <= '0;
      rcnt_q   <= '0;
      rsize_q  <= '0;
      rburst_q <= '0;
      rdata_q  <= '0;
      rresp_q  <= '0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
    end else begin
      case (rstate_q)
        R_IDLE: if (arvalid) begin
          raddr_q  <= araddr;
          rlen_q   <= arlen;
          rsize_q  <= arsize;
          rburst_q <= arburst;
          rcnt_q   <= '0;
          rstate_q <= R_FETCH;
        end
        R_FETCH: begin
          rdata_q  <= rbeat_err ? 32'd0 : mem[word_idx(raddr_q)];
          rresp_q  <= rbeat_err ? 2'b11 : 2'b00;
          rlast_q  <= (rcnt_q == rlen_q);
          rvalid_q <= 1'b1;
          rstate_q <= R_DATA;
        end
        R_DATA: if (rready) begin
          rvalid_q <= 1'b0;
          rlast_q  <= 1'b0;
          if (rlast_q) begin
            rstate_q <= R_IDLE;
          end else begin
            raddr_q  <= raddr_d;
            rcnt_q   <= rcnt_q + 4'd1;
            rstate_q <= R_FETCH;
          end
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_uriscv_axi_sram.sv
`default_nettype none
// ============================================================================
// Module   : tb_uriscv_axi_sram
// Brief    : Self-checking bench for uriscv_axi_sram (vector table + R scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uriscv_axi_sram;
  localparam int unsigned MEM_WORDS = 256;
  localparam logic [31:0] OOR_ADDR  = 32'(MEM_WORDS * 4);

  logic        clk = 1'b0, rst = 1'b1;
  logic [3:0]  awlen = '0, arlen = '0, wstrb = '0;
  logic [2:0]  awsize = '0, arsize = '0;
  logic [1:0]  awburst = '0, arburst = '0;
  logic [31:0] awaddr = '0, araddr = '0, wdata = '0;
  logic        awvalid = 1'b0, wlast = 1'b0, wvalid = 1'b0, bready = 1'b0;
  logic        arvalid = 1'b0, rready = 1'b0;
  logic        awready, wready, bvalid, arready, rlast, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  always #5 clk = ~clk;

  uriscv_axi_sram #(.MEM_WORDS(MEM_WORDS), .BASE_ADDR(32'h0), .INIT_FILE("")) dut (
    .clk(clk), .rst(rst),
    .awlen(awlen), .awsize(awsize), .awburst(awburst), .awaddr(awaddr),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arlen(arlen), .arsize(arsize), .arburst(arburst), .araddr(araddr),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rlast(rlast), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  typedef struct packed {logic [31:0] data; logic last; logic [1:0] resp;} sb_t;
  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [3:0]  strb;
    logic [127:0] data;
  } vec_t;

  sb_t  sb[$];
  sb_t  sb_e;
  vec_t vecs[17];
  int   n_checks = 0, n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // R-channel scoreboard: each handshake pops one expected beat.
  always @(negedge clk) begin
    if (rvalid && rready) begin
      if (sb.size() == 0) begin
        chk("r_unexpected_beat", 32'd1, 32'd0);
      end else begin
        sb_e = sb.pop_front();
        chk("rdata", rdata, sb_e.data);
        chk("rlast", {31'd0, rlast}, {31'd0, sb_e.last});
        chk("rresp", {30'd0, rresp}, {30'd0, sb_e.resp});
      end
    end
  end

  task automatic drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      tick();
      guard++;
    end
    chk("r_drain_timeout", sb.size(), 32'd0);
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [3:0] l, input logic [2:0] s,
                           input logic [1:0] b, input logic [3:0] st, input logic [127:0] d,
                           input logic [1:0] exp_resp, input bit hold_b);
    int guard;
    awaddr = a; awlen = l; awsize = s; awburst = b; awvalid = 1'b1; bready = !hold_b;
    guard = 0;
    while (!awready && guard < 50) begin tick(); guard++; end
    chk("awready_timeout", {31'd0, awready}, 32'd1);
    tick();
    awvalid = 1'b0;
    for (int i = 0; i <= int'(l); i++) begin
      wdata = d[32*i +: 32]; wstrb = st; wvalid = 1'b1; wlast = (i == int'(l));
      guard = 0;
      while (!wready && guard < 50) begin tick(); guard++; end
      chk("wready_timeout", {31'd0, wready}, 32'd1);
      tick();
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk("bvalid_after_last_w", {31'd0, bvalid}, 32'd1);
    chk("bresp", {30'd0, bresp}, {30'd0, exp_resp});
    if (hold_b) begin
      repeat (3) begin
        tick();
        chk("bvalid_held", {31'd0, bvalid}, 32'd1);
        chk("awready_during_b", {31'd0, awready}, 32'd0);
      end
      bready = 1'b1;
    end
    tick();
    bready = 1'b0;
    chk("bvalid_cleared", {31'd0, bvalid}, 32'd0);
    chk("awready_after_b", {31'd0, awready}, 32'd1);
  endtask

  task automatic axi_read(input logic [31:0] a, input logic [3:0] l, input logic [2:0] s,
                          input logic [1:0] b, input logic [127:0] d, input logic [1:0] r);
    int guard;
    for (int i = 0; i <= int'(l); i++)
      sb.push_back('{data: d[32*i +: 32], last: (i == int'(l)), resp: r});
    araddr = a; arlen = l; arsize = s; arburst = b; arvalid = 1'b1; rready = 1'b1;
    guard = 0;
    while (!arready && guard < 50) begin tick(); guard++; end
    chk("arready_timeout", {31'd0, arready}, 32'd1);
    tick();
    arvalid = 1'b0;
    drain();
    rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b1, 32'h10, 4'd3, 3'd2, 2'b01, 4'hF, {32'd4, 32'd3, 32'd2, 32'd1}};
    vecs[1]  = '{1'b0, 32'h10, 4'd3, 3'd2, 2'b01, 4'h0, {32'd4, 32'd3, 32'd2, 32'd1}};
    vecs[2]  = '{1'b1, 32'h20, 4'd0, 3'd2, 2'b01, 4'hF, {96'd0, 32'h11223344}};
    vecs[3]  = '{1'b1, 32'h21, 4'd0, 3'd0, 2'b01, 4'b0010, {96'd0, 32'h0000AB00}};
    vecs[4]  = '{1'b0, 32'h20, 4'd0, 3'd2, 2'b01, 4'h0, {96'd0, 32'h1122AB44}};
    vecs[5]  = '{1'b1, 32'h30, 4'd3, 3'd2, 2'b01, 4'hF, {32'hA3, 32'hA2, 32'hA1, 32'hA0}};
    vecs[6]  = '{1'b1, 32'h40, 4'd0, 3'd2, 2'b01, 4'hF, {96'd0, 32'hC0}};
    vecs[7]  = '{1'b0, 32'h38, 4'd3, 3'd2, 2'b10, 4'h0, {32'hA1, 32'hA0, 32'hA3, 32'hA2}};
    vecs[8]  = '{1'b0, 32'h38, 4'd2, 3'd2, 2'b00, 4'h0, {32'd0, 32'hA2, 32'hA2, 32'hA2}};
    vecs[9]  = '{1'b0, 32'h38, 4'd2, 3'd2, 2'b10, 4'h0, {32'd0, 32'hC0, 32'hA3, 32'hA2}};
    vecs[10] = '{1'b1, 32'h58, 4'd3, 3'd2, 2'b10, 4'hF, {32'hB3, 32'hB2, 32'hB1, 32'hB0}};
    vecs[11] = '{1'b0, 32'h50, 4'd3, 3'd2, 2'b01, 4'h0, {32'hB1, 32'hB0, 32'hB3, 32'hB2}};
    vecs[12] = '{1'b0, 32'h10, 4'd1, 3'd3, 2'b01, 4'h0, {64'd0, 32'd2, 32'd1}};
    vecs[13] = '{1'b0, 32'h10, 4'd3, 3'd0, 2'b01, 4'h0, {32'd1, 32'd1, 32'd1, 32'd1}};
    vecs[14] = '{1'b1, 32'h70, 4'd2, 3'd2, 2'b00, 4'hF, {32'd0, 32'd9, 32'd8, 32'd7}};
    vecs[15] = '{1'b0, 32'h70, 4'd0, 3'd2, 2'b01, 4'h0, {96'd0, 32'd9}};
    vecs[16] = '{1'b1, 32'h00, 4'd0, 3'd2, 2'b01, 4'hF, {96'd0, 32'h5A5A0000}};

    // reset state
    repeat (3) tick();
    chk("awready_in_rst", {31'd0, awready}, 32'd0);
    chk("arready_in_rst", {31'd0, arready}, 32'd0);
    chk("wready_rst", {31'd0, wready}, 32'd0);
    chk("bvalid_rst", {31'd0, bvalid}, 32'd0);
    chk("rvalid_rst", {31'd0, rvalid}, 32'd0);
    chk("rlast_rst", {31'd0, rlast}, 32'd0);
    chk("rdata_rst", rdata, 32'd0);
    chk("bresp_rst", {30'd0, bresp}, 32'd0);
    chk("rresp_rst", {30'd0, rresp}, 32'd0);
    rst = 1'b0;
    #1;
    chk("awready_after_rst", {31'd0, awready}, 32'd1);
    chk("arready_after_rst", {31'd0, arready}, 32'd1);

    for (int i = 0; i < 17; i++) begin
      if (vecs[i].is_wr)
        axi_write(vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].burst, vecs[i].strb,
                  vecs[i].data, 2'b00, 1'b0);
      else
        axi_read(vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].burst, vecs[i].data, 2'b00);
    end

    // R backpressure: 5 stalled cycles on beat 1, first rvalid two cycles after AR
    sb.push_back('{data: 32'd1, last: 1'b0, resp: 2'b00});
    sb.push_back('{data: 32'd2, last: 1'b1, resp: 2'b00});
    araddr = 32'h10; arlen = 4'd1; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1; rready = 1'b0;
    chk("arready_idle", {31'd0, arready}, 32'd1);
    tick();
    arvalid = 1'b0;
    chk("rvalid_during_fetch", {31'd0, rvalid}, 32'd0);
    tick();
    chk("rvalid_first_beat", {31'd0, rvalid}, 32'd1);
    repeat (5) begin
      tick();
      chk("rvalid_stall", {31'd0, rvalid}, 32'd1);
      chk("rdata_stall", rdata, 32'd1);
      chk("rlast_stall", {31'd0, rlast}, 32'd0);
    end
    rready = 1'b1;
    drain();
    rready = 1'b0;

    // B backpressure
    axi_write(32'h80, 4'd0, 3'd2, 2'b01, 4'hF, {96'd0, 32'hBEEF}, 2'b00, 1'b1);
    axi_read(32'h80, 4'd0, 3'd2, 2'b01, {96'd0, 32'hBEEF}, 2'b00);

    // write beat lands on the same edge as R_FETCH of that word
    sb.push_back('{data: 32'hC0, last: 1'b1, resp: 2'b00});
    awaddr = 32'h40; awlen = 4'd0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    wdata = 32'hD0; wstrb = 4'hF; wvalid = 1'b1; wlast = 1'b1; bready = 1'b1;
    araddr = 32'h40; arlen = 4'd0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1; rready = 1'b1;
    chk("awready_conc", {31'd0, awready}, 32'd1);
    chk("arready_conc", {31'd0, arready}, 32'd1);
    tick();
    awvalid = 1'b0; arvalid = 1'b0;
    chk("wready_conc", {31'd0, wready}, 32'd1);
    tick();
    wvalid = 1'b0; wlast = 1'b0;
    chk("bvalid_conc", {31'd0, bvalid}, 32'd1);
    drain();
    rready = 1'b0; bready = 1'b0;
    axi_read(32'h40, 4'd0, 3'd2, 2'b01, {96'd0, 32'hD0}, 2'b00);

    // reset in the middle of a write burst
    awaddr = 32'h60; awlen = 4'd3; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1; bready = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b1; wstrb = 4'hF; wdata = 32'hE0;
    tick();
    wdata = 32'hE1;
    tick();
    wvalid = 1'b0; rst = 1'b1;
    #1;
    chk("awready_gated_rst", {31'd0, awready}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("bvalid_after_abort", {31'd0, bvalid}, 32'd0);
    chk("awready_after_abort", {31'd0, awready}, 32'd1);
    chk("wready_after_abort", {31'd0, wready}, 32'd0);
    tick();
    chk("bvalid_no_resp", {31'd0, bvalid}, 32'd0);
    bready = 1'b0;
    axi_read(32'h60, 4'd1, 3'd2, 2'b01, {64'd0, 32'hE1, 32'hE0}, 2'b00);

    // beyond the array
`ifdef AXI_SRAM_DECERR_EN
    axi_read(OOR_ADDR, 4'd0, 3'd2, 2'b01, 128'd0, 2'b11);
    axi_write(OOR_ADDR, 4'd0, 3'd2, 2'b01, 4'hF, {96'd0, 32'h12345678}, 2'b11, 1'b0);
    axi_read(32'h0, 4'd0, 3'd2, 2'b01, {96'd0, 32'h5A5A0000}, 2'b00);
`else
    axi_read(OOR_ADDR, 4'd0, 3'd2, 2'b01, {96'd0, 32'h5A5A0000}, 2'b00);
    axi_write(OOR_ADDR, 4'd0, 3'd2, 2'b01, 4'hF, {96'd0, 32'h12345678}, 2'b00, 1'b0);
    axi_read(32'h0, 4'd0, 3'd2, 2'b01, {96'd0, 32'h12345678}, 2'b00);
`endif

    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
